// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: round-robin arbiter sharing one sram-like memory port between I-cache and D-cache
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok
);
    typedef enum logic [1:0] {IDLE, WAIT_ADDR, WAIT_DATA} state_t;
    state_t state_q, state_d;
    logic   sel_q, sel_d, last_q, last_d;
    logic   win, cur;
    // pick the owner (fresh winner in IDLE, locked sel otherwise) and mux/route handshakes
    always_comb begin
        win          = (inst_req && data_req) ? ~last_q : data_req;
        cur          = (state_q == IDLE && (inst_req || data_req)) ? win : sel_q;
        mem_req      = state_q == IDLE ? (inst_req || data_req) :
                       state_q == WAIT_ADDR ? (sel_q ? data_req : inst_req) : 1'b0;
        mem_wr       = cur ? data_wr : inst_wr;
        mem_size     = cur ? data_size : inst_size;
        mem_addr     = cur ? data_addr : inst_addr;
        mem_wdata    = cur ? data_wdata : inst_wdata;
        inst_addr_ok = mem_req && mem_addr_ok && !cur;
        data_addr_ok = mem_req && mem_addr_ok && cur;
        inst_data_ok = state_q == WAIT_DATA && mem_data_ok && !sel_q;
        data_data_ok = state_q == WAIT_DATA && mem_data_ok && sel_q;
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
    end
    // next state; last moves only when an address is actually accepted
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        case (state_q)
            IDLE: if (mem_req) begin
                sel_d = win;
                if (mem_addr_ok) begin
                    last_d  = win;
                    state_d = WAIT_DATA;
                end else begin
                    state_d = WAIT_ADDR;
                end
            end
            WAIT_ADDR: if (mem_addr_ok) begin
                last_d  = sel_q;
                state_d = WAIT_DATA;
            end
            WAIT_DATA: if (mem_data_ok) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end
    // state registers; reset drops any outstanding transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed checks of arbitration, lock, routing and async reset
module tb_cache_mem_arbiter;
    logic        clk = 1'b0, rst;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [31:0] inst_rdata, data_rdata, mem_rdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic [4:0]  flags;
    int          tests = 0, fails = 0;

    cache_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok)
    );

    always #5 clk = ~clk;
    assign flags = {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 2'b10; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 2'b10; data_addr = 0; data_wdata = 0;
        mem_rdata = 0; mem_addr_ok = 0; mem_data_ok = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        #3;
        tests++; if (flags !== 5'b00000) begin fails++; $display("FAIL reset_flags got %b exp %b", flags, 5'b00000); end
        tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL reset_mem_addr got %h exp %h", mem_addr, 32'h0); end
        tick();
        rst = 0;
        tick();
        tests++; if (flags !== 5'b00000) begin fails++; $display("FAIL post_reset_flags got %b exp %b", flags, 5'b00000); end
    endtask

    task automatic test_single_read();
        do_reset();
        data_req = 1; data_addr = 32'h1000; mem_addr_ok = 1;
        #2;
        tests++; if (flags !== 5'b10100) begin fails++; $display("FAIL single_c0_flags got %b exp %b", flags, 5'b10100); end
        tests++; if (mem_addr !== 32'h1000) begin fails++; $display("FAIL single_c0_addr got %h exp %h", mem_addr, 32'h1000); end
        tick();
        data_req = 0; mem_addr_ok = 0;
        #2;
        tests++; if (flags !== 5'b00000) begin fails++; $display("FAIL single_c1_flags got %b exp %b", flags, 5'b00000); end
        tick();
        mem_data_ok = 1; mem_rdata = 32'hDEADBEEF;
        #2;
        tests++; if (flags !== 5'b00001) begin fails++; $display("FAIL single_c2_flags got %b exp %b", flags, 5'b00001); end
        tests++; if (data_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL single_rdata got %h exp %h", data_rdata, 32'hDEADBEEF); end
        tick();
        clear_inputs();
        #2;
        tests++; if (flags !== 5'b00000) begin fails++; $display("FAIL single_c3_flags got %b exp %b", flags, 5'b00000); end
        tick();
    endtask

    task automatic test_simultaneous();
        do_reset();
        inst_req = 1; inst_addr = 32'hBFC00000; data_req = 1; data_addr = 32'h2000; mem_addr_ok = 1;
        #2;
        tests++; if (flags !== 5'b10100) begin fails++; $display("FAIL simul_c0_flags got %b exp %b", flags, 5'b10100); end
        tests++; if (mem_addr !== 32'h2000) begin fails++; $display("FAIL simul_c0_addr got %h exp %h", mem_addr, 32'h2000); end
        tick();
        data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        #2;
        tests++; if (flags !== 5'b00001) begin fails++; $display("FAIL simul_c1_flags got %b exp %b", flags, 5'b00001); end
        tick();
        mem_data_ok = 0; mem_addr_ok = 1;
        #2;
        tests++; if (flags !== 5'b11000) begin fails++; $display("FAIL simul_c2_flags got %b exp %b", flags, 5'b11000); end
        tests++; if (mem_addr !== 32'hBFC00000) begin fails++; $display("FAIL simul_c2_addr got %h exp %h", mem_addr, 32'hBFC00000); end
        tick();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        #2;
        tests++; if (flags !== 5'b00010) begin fails++; $display("FAIL simul_c3_flags got %b exp %b", flags, 5'b00010); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_round_robin();
        logic       exp_d;
        logic [4:0] ef;
        do_reset();
        inst_req = 1; inst_addr = 32'h4000; data_req = 1; data_addr = 32'h2000;
        for (int k = 0; k < 6; k++) begin
            exp_d = (k % 2 == 0);
            mem_addr_ok = 1; mem_data_ok = 0;
            #2;
            ef = {1'b1, !exp_d, exp_d, 2'b00};
            tests++; if (flags !== ef) begin fails++; $display("FAIL rr_grant%0d_flags got %b exp %b", k, flags, ef); end
            tests++; if (mem_addr !== (exp_d ? 32'h2000 : 32'h4000)) begin fails++; $display("FAIL rr_grant%0d_addr got %h exp %h", k, mem_addr, exp_d ? 32'h2000 : 32'h4000); end
            tick();
            mem_addr_ok = 0; mem_data_ok = 1;
            #2;
            ef = {3'b000, !exp_d, exp_d};
            tests++; if (flags !== ef) begin fails++; $display("FAIL rr_data%0d_flags got %b exp %b", k, flags, ef); end
            tick();
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_lock();
        do_reset();
        inst_req = 1; inst_addr = 32'h100;
        #2;
        tests++; if (flags !== 5'b10000) begin fails++; $display("FAIL lock_c0_flags got %b exp %b", flags, 5'b10000); end
        tick();
        data_req = 1; data_addr = 32'h200;
        #2;
        tests++; if (mem_addr !== 32'h100) begin fails++; $display("FAIL lock_c1_addr got %h exp %h", mem_addr, 32'h100); end
        tests++; if (flags !== 5'b10000) begin fails++; $display("FAIL lock_c1_flags got %b exp %b", flags, 5'b10000); end
        tick();
        #2;
        tests++; if (mem_addr !== 32'h100) begin fails++; $display("FAIL lock_c2_addr got %h exp %h", mem_addr, 32'h100); end
        tick();
        mem_addr_ok = 1;
        #2;
        tests++; if (flags !== 5'b11000) begin fails++; $display("FAIL lock_c3_flags got %b exp %b", flags, 5'b11000); end
        tests++; if (mem_addr !== 32'h100) begin fails++; $display("FAIL lock_c3_addr got %h exp %h", mem_addr, 32'h100); end
        tick();
        inst_req = 0; mem_addr_ok = 0;
        #2;
        tests++; if (flags !== 5'b00000) begin fails++; $display("FAIL lock_c4_flags got %b exp %b", flags, 5'b00000); end
        tick();
        mem_data_ok = 1;
        #2;
        tests++; if (flags !== 5'b00010) begin fails++; $display("FAIL lock_c5_flags got %b exp %b", flags, 5'b00010); end
        tick();
        mem_data_ok = 0; mem_addr_ok = 1;
        #2;
        tests++; if (flags !== 5'b10100) begin fails++; $display("FAIL lock_c6_flags got %b exp %b", flags, 5'b10100); end
        tests++; if (mem_addr !== 32'h200) begin fails++; $display("FAIL lock_c6_addr got %h exp %h", mem_addr, 32'h200); end
        tick();
        data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        #2;
        tests++; if (flags !== 5'b00001) begin fails++; $display("FAIL lock_c7_flags got %b exp %b", flags, 5'b00001); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_write();
        do_reset();
        data_req = 1; data_wr = 1; data_size = 2'b00; data_addr = 32'h3003; data_wdata = 32'h000000AB;
        inst_wr = 0; inst_size = 2'b10; inst_addr = 32'h5555; inst_wdata = 32'h12345678;
        #2;
        tests++; if ({mem_req, mem_wr, mem_size} !== 4'b1100) begin fails++; $display("FAIL wr_c0_ctl got %b exp %b", {mem_req, mem_wr, mem_size}, 4'b1100); end
        tests++; if ({mem_addr, mem_wdata} !== {32'h3003, 32'h000000AB}) begin fails++; $display("FAIL wr_c0_addr_wdata got %h exp %h", {mem_addr, mem_wdata}, {32'h3003, 32'h000000AB}); end
        tick();
        mem_addr_ok = 1;
        #2;
        tests++; if ({mem_req, mem_wr, mem_size} !== 4'b1100) begin fails++; $display("FAIL wr_c1_ctl got %b exp %b", {mem_req, mem_wr, mem_size}, 4'b1100); end
        tests++; if ({mem_addr, mem_wdata} !== {32'h3003, 32'h000000AB}) begin fails++; $display("FAIL wr_c1_addr_wdata got %h exp %h", {mem_addr, mem_wdata}, {32'h3003, 32'h000000AB}); end
        tests++; if (flags !== 5'b10100) begin fails++; $display("FAIL wr_c1_flags got %b exp %b", flags, 5'b10100); end
        tick();
        data_req = 0; data_wr = 0; mem_addr_ok = 0; mem_data_ok = 1;
        #2;
        tests++; if (flags !== 5'b00001) begin fails++; $display("FAIL wr_c2_flags got %b exp %b", flags, 5'b00001); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        inst_req = 1; inst_addr = 32'h700; mem_addr_ok = 1;
        tick();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hCAFEF00D;
        #1;
        tests++; if (flags !== 5'b00010) begin fails++; $display("FAIL arst_pre_flags got %b exp %b", flags, 5'b00010); end
        rst = 1;
        #1;
        tests++; if (flags !== 5'b00000) begin fails++; $display("FAIL arst_during_flags got %b exp %b", flags, 5'b00000); end
        #1;
        rst = 0;
        tick();
        tests++; if (flags !== 5'b00000) begin fails++; $display("FAIL arst_late_ok_flags got %b exp %b", flags, 5'b00000); end
        mem_data_ok = 0; inst_req = 1; mem_addr_ok = 1;
        #2;
        tests++; if (flags !== 5'b11000) begin fails++; $display("FAIL arst_new_req_flags got %b exp %b", flags, 5'b11000); end
        tick();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        #2;
        tests++; if (flags !== 5'b00010) begin fails++; $display("FAIL arst_new_data_flags got %b exp %b", flags, 5'b00010); end
        tick();
        clear_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_single_read();
        test_round_robin();
        test_lock();
        test_write();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
